// File: rtl/reg32_write_arbiter.sv
`default_nettype none
// =============================================================================
// reg32_write_arbiter: round-robin write arbiter that owns en/din of one shared register
// Rev 1.0 | optional `ARB_LOCK_EN` adds a per-requester lock for back-to-back writes
// =============================================================================
module reg32_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
   input  logic [NREQ-1:0]       lock,
`endif
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      rdata,
   output logic                  busy,
   output logic                  reg_en,
   output logic [WIDTH-1:0]      reg_din,
   input  logic [WIDTH-1:0]      reg_dout
);

   localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_ACK   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SELW-1:0]   r_sel;
   logic [SELW-1:0]   r_ptr;
   logic [SELW-1:0]   w_win;
   logic [SELW-1:0]   w_sel_nxt;
   logic [SELW-1:0]   w_ptr_nxt;
   logic [WIDTH-1:0]  r_data;
   logic [WIDTH-1:0]  w_data_nxt;
   logic              w_found;
   logic              w_chain;
   int                w_idx;
   logic [NREQ-1:0]   w_onehot;
   logic [WIDTH-1:0]  w_words [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_words[gi] = wdata[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Search starts one past the last winner and wraps, so the last winner has lowest priority.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      w_idx   = 0;
      for (int off = 1; off <= NREQ; off++) begin
         w_idx = int'(r_ptr) + off;
         if (w_idx >= NREQ) begin
            w_idx = w_idx - NREQ;
         end
         if (!w_found && req[SELW'(w_idx)]) begin
            w_found = 1'b1;
            w_win   = SELW'(w_idx);
         end
      end
   end

`ifdef ARB_LOCK_EN
   assign w_chain = req[r_sel] & lock[r_sel];
`else
   assign w_chain = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_data_nxt  = r_data;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_WRITE;
               w_sel_nxt   = w_win;
               w_data_nxt  = w_words[w_win];
            end
         end
         S_WRITE: begin
            w_state_nxt = S_ACK;
         end
         S_ACK: begin
            // A locked owner re-enters WRITE directly and leaves the pointer untouched.
            if (w_chain) begin
               w_state_nxt = S_WRITE;
               w_data_nxt  = w_words[r_sel];
            end else begin
               w_state_nxt = S_IDLE;
               w_ptr_nxt   = r_sel;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sel   <= '0;
         r_ptr   <= SELW'(NREQ - 1);
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_data  <= w_data_nxt;
      end
   end

   assign w_onehot = NREQ'(1) << r_sel;
   assign gnt      = (r_state == S_WRITE) ? w_onehot : '0;
   assign ack      = (r_state == S_ACK)   ? w_onehot : '0;
   assign reg_en   = (r_state == S_WRITE);
   assign busy     = (r_state != S_IDLE);
   assign reg_din  = r_data;
   assign rdata    = reg_dout;

endmodule
`default_nettype wire

// File: tb/tb_reg32_write_arbiter.sv
`default_nettype none
// =============================================================================
// tb_reg32_write_arbiter: randomized scoreboard bench with a transaction-level arbiter model
// Rev 1.0 | exercises the lock path when ARB_LOCK_EN is defined
// =============================================================================
module tb_reg32_write_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int DEPTH = 512;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] wdata = '0;
   logic [NREQ-1:0]       lock = '0;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      rdata;
   logic                  busy;
   logic                  reg_en;
   logic [WIDTH-1:0]      reg_din;
   logic [WIDTH-1:0]      reg_q;

   reg32_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wdata    (wdata),
`ifdef ARB_LOCK_EN
      .lock     (lock),
`endif
      .gnt      (gnt),
      .ack      (ack),
      .rdata    (rdata),
      .busy     (busy),
      .reg_en   (reg_en),
      .reg_din  (reg_din),
      .reg_dout (reg_q)
   );

   always #5 clk = ~clk;

   // The shared register sitting behind the arbiter.
   always_ff @(posedge clk) begin
      if (rst)         reg_q <= '0;
      else if (reg_en) reg_q <= reg_din;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      int               sel;
      logic [WIDTH-1:0] data;
   } txn_t;

   txn_t gq[$];
   txn_t aq[$];
   int   glog_sel[$];
   int   glog_cyc[$];

   // Transaction-level model: phase 0 idle, 1 write, 2 ack.
   int m_phase = 0;
   int m_ptr   = NREQ - 1;
   int m_sel   = 0;

   function automatic bit model_locked(int s);
`ifdef ARB_LOCK_EN
      return ((int'(req) >> s) & 1) == 1 && ((int'(lock) >> s) & 1) == 1;
`else
      return (s < 0);
`endif
   endfunction

   task automatic model_push(int s);
      txn_t t;
      t.sel  = s;
      t.data = wdata[s*WIDTH +: WIDTH];
      gq.push_back(t);
      aq.push_back(t);
   endtask

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
         m_phase = 0;
         m_ptr   = NREQ - 1;
         gq.delete();
         aq.delete();
      end else if (m_phase == 0) begin
         if (req != 0) begin
            for (int k = 1; k <= NREQ; k++) begin
               int idx;
               idx = (m_ptr + k) % NREQ;
               if (((int'(req) >> idx) & 1) == 1) begin
                  m_sel = idx;
                  break;
               end
            end
            model_push(m_sel);
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else begin
         if (model_locked(m_sel)) begin
            model_push(m_sel);
            m_phase = 1;
         end else begin
            m_ptr   = m_sel;
            m_phase = 0;
         end
      end
   end

   // Monitor: compares DUT outputs against the scoreboard away from the active edge.
   txn_t mt;
   initial forever begin
      @(negedge clk);
      check("gnt_ack_excl", 64'((gnt != 0) && (ack != 0)), 0);
      check("busy", busy, 64'(m_phase != 0));
      check("reg_en", reg_en, 64'(m_phase == 1));
      if (m_phase == 1) begin
         if (gq.size() > 0) begin
            mt = gq.pop_front();
            check("gnt", gnt, 64'(1) << mt.sel);
            check("reg_din", reg_din, mt.data);
            glog_sel.push_back(mt.sel);
            glog_cyc.push_back(cyc);
         end else begin
            check("gnt_no_txn", 1, 0);
         end
      end else begin
         check("gnt_idle", gnt, 0);
      end
      if (m_phase == 2) begin
         if (aq.size() > 0) begin
            mt = aq.pop_front();
            check("ack", ack, 64'(1) << mt.sel);
            check("rdata", rdata, mt.data);
         end else begin
            check("ack_no_txn", 1, 0);
         end
      end else begin
         check("ack_idle", ack, 0);
      end
   end

   // Requester clients: each holds a FIFO of words and keeps req high while it has work.
   logic [WIDTH-1:0] mem [NREQ][DEPTH];
   int  head [NREQ];
   int  tail [NREQ];
   bit  drop [NREQ];
   int  drop_mode  = 0;  // 0 never, 1 always, 2 random
   int  scrib_mode = 0;
   bit  lock_rand  = 0;
   logic [NREQ-1:0] lock_drv = '0;

   task automatic push_word(int i, logic [WIDTH-1:0] w);
      mem[i][tail[i]] = w;
      tail[i]++;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (ack[i]) begin
            head[i]++;
            drop[i] = 1'b0;
         end
         if (gnt[i] && (drop_mode == 1 || (drop_mode == 2 && $urandom_range(0, 1) == 1)))
            drop[i] = 1'b1;
         req[i] = (head[i] != tail[i]) && !drop[i];
         if (gnt[i] && (scrib_mode == 1 || (scrib_mode == 2 && $urandom_range(0, 1) == 1)))
            wdata[i*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
         else
            wdata[i*WIDTH +: WIDTH] = (head[i] != tail[i]) ? mem[i][head[i]] : '0;
         lock[i] = lock_rand ? 1'($urandom_range(0, 1)) : (lock_drv[i] && head[i] != tail[i]);
      end
   endtask

   task automatic drain(int lim);
      bit done;
      done = 1'b0;
      for (int c = 0; c < lim && !done; c++) begin
         tick();
         done = all_empty() && (m_phase == 0);
      end
      check("drain_done", done, 1);
      check("drain_scoreboard", 64'(aq.size()), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) drop[i] = 1'b0;
   endtask

   int lb;
   int w;

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
         drop[i] = 1'b0;
      end
      repeat (3) tick();
      check("rst_gnt", gnt, 0);
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_reg_en", reg_en, 0);
      check("rst_reg_din", reg_din, 0);
      rst = 1'b0;

      // Single write from requester 0.
      lb = glog_sel.size();
      push_word(0, 32'hA5A5_A5A5);
      drain(50);
      check("t1_winner", 64'(glog_sel[lb]), 0);
      check("t1_reg", reg_q, 32'hA5A5_A5A5);

      // All requesting: rotation 0,1,2,3 then 0 again, 3 cycles apart.
      do_reset();
      lb = glog_sel.size();
      for (int i = 0; i < NREQ; i++) push_word(i, 32'h1111_1111 * (i + 1));
      push_word(0, 32'h1111_1111);
      drain(100);
      for (int k = 0; k < 5; k++) check("t2_order", 64'(glog_sel[lb+k]), 64'(k % NREQ));
      for (int k = 1; k < 5; k++) check("t2_spacing", 64'(glog_cyc[lb+k] - glog_cyc[lb+k-1]), 3);

      // Request withdrawn during WRITE still completes.
      drop_mode = 1;
      push_word(2, 32'hDEAD_BEEF);
      drain(50);
      drop_mode = 0;
      check("t3_reg", reg_q, 32'hDEAD_BEEF);

      // Data changed during WRITE is not picked up.
      scrib_mode = 1;
      push_word(1, 32'h0000_0001);
      drain(50);
      scrib_mode = 0;
      check("t4_reg", reg_q, 32'h0000_0001);

      // Reset during WRITE aborts without ack; pointer restarts at requester 0.
      push_word(1, 32'h1111_0000);
      push_word(2, 32'h2222_0000);
      push_word(3, 32'h3333_0000);
      w = 0;
      while (gnt == 0 && w < 20) begin
         tick();
         w++;
      end
      check("t5_inflight", gnt, 4'b0100);
      rst = 1'b1;
      head[2] = tail[2];
      req[2] = 1'b0;
      tick();
      check("t5_gnt", gnt, 0);
      check("t5_ack", ack, 0);
      check("t5_reg_en", reg_en, 0);
      check("t5_busy", busy, 0);
      rst = 1'b0;
      lb = glog_sel.size();
      drain(100);
      check("t5_first", 64'(glog_sel[lb]), 1);
      check("t5_second", 64'(glog_sel[lb+1]), 3);

`ifdef ARB_LOCK_EN
      // Locked requester 3 writes three words back to back before requester 0 gets in.
      do_reset();
      lock_drv = 4'b1000;
      lb = glog_sel.size();
      push_word(3, 32'h3000_0001);
      push_word(3, 32'h3000_0002);
      push_word(3, 32'h3000_0003);
      tick();
      push_word(0, 32'h0000_00AA);
      drain(100);
      lock_drv = '0;
      for (int k = 0; k < 3; k++) check("t6_locked", 64'(glog_sel[lb+k]), 3);
      check("t6_after", 64'(glog_sel[lb+3]), 0);
      check("t6_sp1", 64'(glog_cyc[lb+1] - glog_cyc[lb]), 2);
      check("t6_sp2", 64'(glog_cyc[lb+2] - glog_cyc[lb+1]), 2);
      lock_rand = 1'b1;
`endif

      // Randomized traffic with random withdrawals and data changes.
      do_reset();
      drop_mode  = 2;
      scrib_mode = 2;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 2) == 0) push_word($urandom_range(0, NREQ - 1), $urandom());
         tick();
      end
      lock_rand = 1'b0;
      drain(4000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg32_write_arbiter.md
Name: reg32_write_arbiter

Overview:
Round-robin arbiter that shares one 32-bit enable-gated register (clk/rst/en/din/dout) among NREQ requesters. It latches the winning requester's write data and drives the register's en/din for exactly one cycle. It then returns an ack with the read-back register value. It sits between client blocks and the shared Reg32 instance, and owns that register's en and din pins.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, data width; must match the shared register width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester write request, level; held until ack
wdata  in  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  out  NREQ  one-hot grant; high during the WRITE cycle of the winner
ack  out  NREQ  one-hot completion pulse; high during the ACK cycle of the winner
rdata  out  WIDTH  read-back value of the shared register; valid only while any ack bit is high
busy  out  1  high in WRITE and ACK states
reg_en  out  1  enable to the shared register
reg_din  out  WIDTH  data to the shared register
reg_dout  in  WIDTH  current output of the shared register

Behaviour:
- One clock (clk). Synchronous active-high reset (rst). All state updates on the rising edge of clk.
- Reset values:
  - state=IDLE; gnt=0; ack=0; reg_en=0; reg_din=0; busy=0.
  - rdata is don't-care (bench must not check it without ack).
  - last-winner pointer ptr=NREQ-1, so requester 0 has top priority first.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If req != 0, select the winner by round-robin: the first set bit searching ptr+1, ptr+2, ... with modulo-NREQ wrap.
  - On that edge, register sel=winner and data_q=wdata[winner], then go to WRITE.
  - If req == 0, stay in IDLE.
- WRITE (exactly 1 cycle):
  - reg_en=1, reg_din=data_q, gnt[sel]=1, busy=1.
  - Next state is always ACK.
  - The transaction is committed: a req drop during WRITE does not cancel it.
- ACK (exactly 1 cycle):
  - The register has loaded data_q at the edge that ended WRITE.
  - ack[sel]=1; rdata=reg_dout (combinational passthrough); reg_en=0; busy=1.
  - ptr<=sel; next state IDLE.
- Latency: req seen at edge N -> gnt/reg_en high in cycle N+1 -> ack in cycle N+2.
- Throughput: 1 write per 3 cycles.
- A requester must drop req in the cycle after ack. If req is still high when IDLE is re-entered, it is treated as a new request.
- reg_din holds data_q outside WRITE. The register ignores it because reg_en=0.
- Simultaneous requests: only one grant per transaction. Losers keep req high and wait; they are never dropped.
- Fairness: any continuously asserted req is granted within NREQ transactions.
- wdata is sampled only on the IDLE->WRITE edge. Later changes have no effect on that transaction.
- Reset in any state: return to IDLE with all outputs at reset values the next cycle.
  - A write in flight may or may not have reached the register; the register shares the same rst and clears anyway.
  - No ack is issued for an aborted transaction.
- gnt and ack are never both nonzero. gnt is never more than one-hot.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds input port lock (NREQ bits).
  - In ACK, if req[sel] and lock[sel] are both high, capture data_q=wdata[sel] and go directly to WRITE with the same sel.
  - This skips arbitration and does not update ptr, giving back-to-back writes at 1 per 2 cycles.
  - On releasing lock, the next arbitration starts from ptr+1, where ptr is the locked requester.
- When undefined: the lock port is absent and behaviour is exactly as above.

Test Plan:
1. Reset, then req=4'b0001 with wdata[0]=32'hA5A5A5A5 -> gnt=0001 and reg_en=1 in cycle 1; ack=0001 and rdata=32'hA5A5A5A5 in cycle 2; busy low in cycle 3.
2. req=4'b1111 held, wdata[i]=32'h1111_1111*(i+1) -> grant order 0,1,2,3,0; each rdata equals the granted requester's value; one transaction every 3 cycles.
3. req[2] drops during WRITE -> write of 32'hDEADBEEF still completes; ack[2] pulses; reg_dout=32'hDEADBEEF.
4. wdata[1] changes 32'h0000_0001 -> 32'hFFFF_FFFF during WRITE -> register loads 32'h0000_0001.
5. rst=1 asserted during WRITE -> next cycle gnt=0, ack=0, reg_en=0, busy=0, no ack pulse. Subsequent req=4'b1010 grants requester 1 first.
6. ARB_LOCK_EN: lock[3]=1 and req[3]=1 with three data words while req[0]=1 -> requester 3 writes all three at 2-cycle spacing. After lock drops, requester 0 is granted next.
